// File: rtl/game_ctrl_pkg.sv
// ============================================================================
// game_ctrl_pkg: shared state encoding, index type and default game tables
// Rev 1.0
// ============================================================================
`default_nettype none
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_WON    = 3'd3,
    ST_OVER   = 3'd4
  } game_state_t;

  localparam int DEF_NUM_OBJ = 4;
  localparam int DEF_IDX_W   = $clog2(DEF_NUM_OBJ);
  localparam int DEF_SEQ_LEN = 8;

  typedef logic [DEF_IDX_W-1:0] obj_idx_t;

  // Slot 0 sits in the least significant field.
  localparam logic [DEF_SEQ_LEN*DEF_IDX_W-1:0] DEF_SPAWN_SEQ =
    {2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  localparam logic [DEF_NUM_OBJ-1:0] DEF_SCORE_PASS_M = 4'b0110;
  localparam logic [DEF_NUM_OBJ-1:0] DEF_SCORE_HIT_M  = 4'b0001;
  localparam logic [DEF_NUM_OBJ-1:0] DEF_FUEL_HIT_M   = 4'b0001;
  localparam logic [DEF_NUM_OBJ-1:0] DEF_SPEED_HIT_M  = 4'b1110;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_sequencer.sv
// ============================================================================
// spawn_sequencer: walks the spawn table and raises the level on every wrap
// Rev 1.0
// ============================================================================
`default_nettype none
module spawn_sequencer
  import game_ctrl_pkg::*;
#(
  parameter int NUM_OBJ   = DEF_NUM_OBJ,
  parameter int SEQ_LEN   = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN*$clog2(NUM_OBJ)-1:0] SPAWN_SEQ = DEF_SPAWN_SEQ,
  parameter int MAX_LEVEL = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           advance,
  output logic [$clog2(NUM_OBJ)-1:0]     obj_idx,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int LVL_W = $clog2(MAX_LEVEL + 1);
  localparam int PTR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic [PTR_W-1:0] seq_ptr_q, seq_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [IDX_W-1:0] seq_tbl [SEQ_LEN];

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_seq_tbl
    assign seq_tbl[g] = SPAWN_SEQ[g*IDX_W +: IDX_W];
  end

  always_comb begin
    seq_ptr_d = seq_ptr_q;
    level_d   = level_q;
    if (clear) begin
      seq_ptr_d = '0;
      level_d   = '0;
    end else if (advance) begin
      if (seq_ptr_q == PTR_W'(SEQ_LEN - 1)) begin
        seq_ptr_d = '0;
        if (level_q != LVL_W'(MAX_LEVEL)) level_d = level_q + 1'b1;
      end else begin
        seq_ptr_d = seq_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_ptr_q <= '0;
      level_q   <= '0;
    end else begin
      seq_ptr_q <= seq_ptr_d;
      level_q   <= level_d;
    end
  end

  assign obj_idx = seq_tbl[seq_ptr_q];
  assign level   = level_q;

endmodule
`default_nettype wire

// File: rtl/game_spawn_scheduler.sv
// ============================================================================
// game_spawn_scheduler: spawn FSM, wait timer and registered game outputs
// Rev 1.0
// ============================================================================
`default_nettype none
module game_spawn_scheduler
  import game_ctrl_pkg::*;
#(
  parameter int NUM_OBJ     = DEF_NUM_OBJ,
  parameter int SEQ_LEN     = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN*$clog2(NUM_OBJ)-1:0] SPAWN_SEQ = DEF_SPAWN_SEQ,
  parameter int START_DELAY = 6,
  parameter int WAIT_PASS   = 3,
  parameter int WAIT_HIT    = 4,
  parameter int MAX_LEVEL   = 2,
  parameter logic [NUM_OBJ-1:0] SCORE_PASS_M = DEF_SCORE_PASS_M,
  parameter logic [NUM_OBJ-1:0] SCORE_HIT_M  = DEF_SCORE_HIT_M,
  parameter logic [NUM_OBJ-1:0] FUEL_HIT_M   = DEF_FUEL_HIT_M,
  parameter logic [NUM_OBJ-1:0] SPEED_HIT_M  = DEF_SPEED_HIT_M
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           one_sec,
  input  logic                           enter,
  input  logic                           pause,
  input  logic                           game_over,
  input  logic                           game_won,
  input  logic                           player_req,
  input  logic [NUM_OBJ-1:0]             obj_req,
  input  logic [NUM_OBJ-1:0]             obj_passed,
  output logic [NUM_OBJ-1:0]             obj_enable,
  output logic                           spawn_pulse,
  output logic                           score_add,
  output logic                           fuel_add,
  output logic                           speed_reset,
  output logic                           idle_request,
  output logic                           win_flag,
  output logic                           over_flag,
  output logic [$clog2(MAX_LEVEL+1)-1:0] level
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int TMR_W = $clog2(max3(START_DELAY, WAIT_PASS, WAIT_HIT)) + 1;
  localparam logic [TMR_W-1:0] C_START     = TMR_W'(START_DELAY);
  localparam logic [TMR_W-1:0] C_WAIT_PASS = TMR_W'(WAIT_PASS);
  localparam logic [TMR_W-1:0] C_WAIT_HIT  = TMR_W'(WAIT_HIT);

  game_state_t        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   active_idx_q, active_idx_d;
  logic [NUM_OBJ-1:0] obj_enable_q, obj_enable_d;
  logic spawn_q, spawn_d, score_q, score_d, fuel_q, fuel_d;
  logic speed_q, speed_d, idle_q, idle_d, win_q, win_d, over_q, over_d;
  logic speed_pulse, advance, seq_clear, hit, passed;
  logic [IDX_W-1:0]   seq_idx;
  logic [TMR_W-1:0]   level_ext, pass_wait;

  spawn_sequencer #(
    .NUM_OBJ   (NUM_OBJ),
    .SEQ_LEN   (SEQ_LEN),
    .SPAWN_SEQ (SPAWN_SEQ),
    .MAX_LEVEL (MAX_LEVEL)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (seq_clear),
    .advance (advance),
    .obj_idx (seq_idx),
    .level   (level)
  );

  assign hit    = player_req & obj_req[active_idx_q];
  assign passed = obj_passed[active_idx_q];

  // Harder levels shorten the post-pass wait, but never below one tick.
  assign level_ext = TMR_W'(level);
  assign pass_wait = (level_ext >= C_WAIT_PASS - TMR_W'(1)) ? TMR_W'(1)
                                                            : C_WAIT_PASS - level_ext;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    active_idx_d = active_idx_q;
    spawn_d      = 1'b0;
    score_d      = 1'b0;
    fuel_d       = 1'b0;
    speed_pulse  = 1'b0;
    advance      = 1'b0;
    seq_clear    = 1'b0;

    if (game_over && state_q != ST_IDLE) begin
      state_d = ST_OVER;
    end else if (game_won && state_q != ST_IDLE) begin
      state_d = ST_WON;
    end else if (!pause) begin
      case (state_q)
        ST_IDLE: begin
          if (enter) begin
            state_d = ST_WAIT;
            timer_d = C_START;
          end
        end
        ST_WAIT: begin
          // A tick landing on the spawn cycle is swallowed by the spawn.
          if (timer_q == '0) begin
            state_d      = ST_ACTIVE;
            active_idx_d = seq_idx;
            spawn_d      = 1'b1;
            advance      = 1'b1;
          end else if (one_sec) begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (hit) begin
            state_d     = ST_WAIT;
            timer_d     = C_WAIT_HIT;
            score_d     = SCORE_HIT_M[active_idx_q];
            fuel_d      = FUEL_HIT_M[active_idx_q];
            speed_pulse = SPEED_HIT_M[active_idx_q];
          end else if (passed) begin
            state_d = ST_WAIT;
            timer_d = pass_wait;
            score_d = SCORE_PASS_M[active_idx_q];
          end
        end
        ST_WON, ST_OVER: begin
          if (enter) begin
            state_d      = ST_IDLE;
            timer_d      = C_START;
            active_idx_d = '0;
            seq_clear    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    obj_enable_d = '0;
    if (state_d == ST_ACTIVE) obj_enable_d[active_idx_d] = 1'b1;
    speed_d = speed_pulse | (state_d == ST_WON) | (state_d == ST_OVER);
    idle_d  = (state_d == ST_IDLE);
    win_d   = (state_d == ST_WON);
    over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= C_START;
      active_idx_q <= '0;
      obj_enable_q <= '0;
      spawn_q      <= 1'b0;
      score_q      <= 1'b0;
      fuel_q       <= 1'b0;
      speed_q      <= 1'b0;
      idle_q       <= 1'b1;
      win_q        <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      active_idx_q <= active_idx_d;
      obj_enable_q <= obj_enable_d;
      spawn_q      <= spawn_d;
      score_q      <= score_d;
      fuel_q       <= fuel_d;
      speed_q      <= speed_d;
      idle_q       <= idle_d;
      win_q        <= win_d;
      over_q       <= over_d;
    end
  end

  assign obj_enable   = obj_enable_q;
  assign spawn_pulse  = spawn_q;
  assign score_add    = score_q;
  assign fuel_add     = fuel_q;
  assign speed_reset  = speed_q;
  assign idle_request = idle_q;
  assign win_flag     = win_q;
  assign over_flag    = over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_spawn_scheduler.sv
// ============================================================================
// tb_game_spawn_scheduler: directed game flow with a pulse-event scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none
module tb_game_spawn_scheduler;
  import game_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset, one_sec, enter, pause, game_over, game_won, player_req;
  logic [3:0] obj_req, obj_passed, obj_enable;
  logic spawn_pulse, score_add, fuel_add, speed_reset, idle_request, win_flag, over_flag;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       spawn;
    logic       score;
    logic       fuel;
    logic       speed;
    logic [3:0] en;
  } ev_t;
  ev_t sb[$];

  int seq_tbl [8] = '{0, 1, 2, 0, 1, 0, 0, 2};
  logic [3:0] m_sp = 4'b0110;
  logic [3:0] m_sh = 4'b0001;
  logic [3:0] m_fh = 4'b0001;
  logic [3:0] m_vh = 4'b1110;
  int m_ptr, m_level, n_spawn, w;
  obj_idx_t cur;

  always #5 clk = ~clk;

  game_spawn_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .one_sec      (one_sec),
    .enter        (enter),
    .pause        (pause),
    .game_over    (game_over),
    .game_won     (game_won),
    .player_req   (player_req),
    .obj_req      (obj_req),
    .obj_passed   (obj_passed),
    .obj_enable   (obj_enable),
    .spawn_pulse  (spawn_pulse),
    .score_add    (score_add),
    .fuel_add     (fuel_add),
    .speed_reset  (speed_reset),
    .idle_request (idle_request),
    .win_flag     (win_flag),
    .over_flag    (over_flag),
    .level        (level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every pulse the DUT raises must match the oldest expected event.
  always @(negedge clk) begin : mon
    ev_t got, e;
    if (reset !== 1'b1 &&
        (spawn_pulse | score_add | fuel_add | (speed_reset & ~win_flag & ~over_flag)) === 1'b1) begin
      got = {spawn_pulse, score_add, fuel_add, speed_reset, obj_enable};
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed %0h expected none", got);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (got === e) else begin
          errors++;
          $error("FAIL pulse_event: observed %0h expected %0h", got, e);
        end
      end
    end
  end

  task automatic model_clear();
    m_ptr   = 0;
    m_level = 0;
  endtask

  task automatic wait_spawn(input int exp_ticks);
    int n;
    logic seen;
    logic [3:0] en;
    cur = obj_idx_t'(seq_tbl[m_ptr]);
    en  = 4'b0001 << cur;
    sb.push_back({1'b1, 1'b0, 1'b0, 1'b0, en});
    m_ptr = (m_ptr == 7) ? 0 : m_ptr + 1;
    if (m_ptr == 0 && m_level < 2) m_level++;
    n_spawn++;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      one_sec = 1'b1;
      step();
      one_sec = 1'b0;
      n++;
      step();
      seen = spawn_pulse;
    end
    chk("spawn_ticks", seen ? n : 99, exp_ticks);
    chk("spawn_enable", obj_enable, en);
    chk("level", level, m_level);
  endtask

  task automatic resolve(input logic do_hit, input logic do_pass, output int wait_t);
    logic [3:0] oh;
    ev_t e;
    oh = 4'b0001 << cur;
    if (do_hit) e = {1'b0, m_sh[cur], m_fh[cur], m_vh[cur], 4'b0000};
    else        e = {1'b0, m_sp[cur], 1'b0, 1'b0, 4'b0000};
    if (e.score | e.fuel | e.speed) sb.push_back(e);
    player_req = do_hit;
    obj_req    = do_hit ? oh : 4'b0000;
    obj_passed = do_pass ? oh : 4'b0000;
    step();
    player_req = 1'b0;
    obj_req    = 4'b0000;
    obj_passed = 4'b0000;
    if (do_hit) wait_t = 4;
    else        wait_t = (m_level >= 2) ? 1 : 3 - m_level;
  endtask

  task automatic paused_ticks(input int n);
    pause = 1'b1;
    for (int i = 0; i < n; i++) begin
      one_sec = 1'b1;
      if (i == 4) begin
        player_req = 1'b1;
        obj_req    = 4'b1111;
        obj_passed = 4'b1111;
      end
      step();
      one_sec    = 1'b0;
      player_req = 1'b0;
      obj_req    = 4'b0000;
      obj_passed = 4'b0000;
      step();
    end
    pause = 1'b0;
  endtask

  initial begin
    reset = 1'b1; one_sec = 1'b0; enter = 1'b0; pause = 1'b0;
    game_over = 1'b0; game_won = 1'b0; player_req = 1'b0;
    obj_req = 4'b0000; obj_passed = 4'b0000;
    n_spawn = 0;
    model_clear();
    repeat (3) step();
    chk("rst_idle", idle_request, 1'b1);
    chk("rst_enable", obj_enable, 4'b0000);
    chk("rst_level", level, 2'd0);
    chk("rst_pulses", {spawn_pulse, score_add, fuel_add, speed_reset}, 4'b0000);
    chk("rst_flags", {win_flag, over_flag}, 2'b00);
    reset = 1'b0;
    step();
    step();
    enter = 1'b1;
    step();
    enter = 1'b0;
    chk("start_idle_low", idle_request, 1'b0);

    wait_spawn(6);
    resolve(1'b1, 1'b0, w);
    wait_spawn(w);
    while (n_spawn < 26) begin
      resolve(1'b0, 1'b1, w);
      wait_spawn(w);
    end

    // obj 1 active: a hit with a simultaneous pass gives only the hit outcome
    chk("dual_obj", obj_enable, 4'b0010);
    resolve(1'b1, 1'b1, w);
    wait_spawn(w);

    paused_ticks(10);
    chk("pause_active_hold", obj_enable, 4'b0100);
    step();
    chk("pause_active_after", obj_enable, 4'b0100);
    resolve(1'b0, 1'b1, w);
    paused_ticks(10);
    chk("pause_wait_hold", obj_enable, 4'b0000);
    wait_spawn(w);

    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("over_flag", over_flag, 1'b1);
    chk("over_enable", obj_enable, 4'b0000);
    chk("over_speed", speed_reset, 1'b1);
    step();
    chk("over_speed_held", speed_reset, 1'b1);
    enter = 1'b1;
    step();
    enter = 1'b0;
    model_clear();
    chk("restart_idle", idle_request, 1'b1);
    chk("restart_level", level, 2'd0);
    chk("restart_flags", {over_flag, speed_reset}, 2'b00);

    enter = 1'b1;
    step();
    enter = 1'b0;
    wait_spawn(6);
    resolve(1'b0, 1'b1, w);
    wait_spawn(w);
    game_won = 1'b1;
    step();
    game_won = 1'b0;
    chk("won_flag", win_flag, 1'b1);
    chk("won_enable", obj_enable, 4'b0000);
    chk("won_speed", speed_reset, 1'b1);
    enter = 1'b1;
    step();
    step();
    enter = 1'b0;
    model_clear();
    chk("won_restart_wait", {idle_request, win_flag}, 2'b00);

    repeat (2) begin
      one_sec = 1'b1;
      step();
      one_sec = 1'b0;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wait_reset_idle", idle_request, 1'b1);
    model_clear();
    enter = 1'b1;
    step();
    enter = 1'b0;
    wait_spawn(6);

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
